timer_irq_ctrl: RTL and testbench
=================================

// Module: timer_irq_ctrl
// PURPOSE
// - Memory-mapped interval timer and interrupt scheduler for the pipelined MIPS core.
// - Counts TL up toward overflow, reloads TL from TH and raises a pending interrupt.
// - Drives the IRQ input of the decode-stage control unit and holds it until the pipeline acknowledges.
// - Masks further IRQs while the core runs in kernel mode (PC[31]=1); re-arms on return to user mode.
// PARAMETERS
// - BASE_ADDR  32'h4000_0000  address of TH; TL at +4, TCON at +8
// - PRESC_W    8              prescaler width (used only with TIMER_PRESCALE_EN)
// PORTS
// - clk        in   1   system clock; all state on rising edge
// - reset      in   1   synchronous, active-low reset
// - addr       in   32  bus address from MEM stage
// - wdata      in   32  bus write data
// - we         in   1   bus write strobe (one cycle per store)
// - re         in   1   bus read strobe
// - rdata      out  32  read data; combinational; 0 when re=0 or address unmapped
// - pc_31      in   1   PC[31] of the instruction currently in ID (kernel-mode flag)
// - irq_ack    in   1   pipeline took the interrupt this cycle (IRQ && !pc_31 && no ID stall)
// - irq        out  1   interrupt request to the control unit
// - tl_ovf     out  1   one-cycle pulse on TL overflow (debug/LED hook)
// BEHAVIOUR
// - Registers: TH[31:0], TL[31:0], TCON[2:0] = {status, irq_en, run}. TCON[31:3] read as 0.
// - Reset (reset=0 at clk edge): TH=0, TL=0, TCON=0, state=IDLE, irq=0, tl_ovf=0, prescaler=0.
// - Counting: when run=1 (and prescale tick, if enabled) TL<=TL+1 each cycle.
// - TL==32'hFFFF_FFFF with count enabled: next TL<=TH, tl_ovf=1 for that cycle, status<=1 if irq_en=1.
// - Writes: we with matching addr updates the register on the same edge; write beats count/reload on TL.
// - TCON write: run, irq_en taken from wdata; status cleared only by writing 0 to bit 2 (writing 1 is ignored).
// - Same-cycle status clear and overflow-set: set wins (no lost interrupt).
// - Reads: rdata = {TH | TL | {29'b0,TCON}} for matched addr; unmapped -> 0.
// - FSM (state register, 2 bits):
//   IDLE    : irq=0; status&irq_en -> PENDING.
//   PENDING : irq=1; irq_ack -> ENTER; irq_en cleared by write -> IDLE (request withdrawn).
//   ENTER   : irq=0; wait for pc_31=1 (handler fetched) -> KERNEL.
//   KERNEL  : irq=0; pc_31=0 (eret/jr $k0 returned to user) -> IDLE.
// - irq is a registered output: asserted the cycle after entering PENDING, deasserted the cycle after irq_ack.
// - irq never asserted while pc_31=1; irq_ack received outside PENDING is ignored.
// - Status left set on return to IDLE re-raises irq next cycle (handler must clear it).
// - Reset mid-operation (any state): returns to IDLE with irq=0 on that edge; pending interrupt discarded.
// CONFIGURATION
// - TIMER_PRESCALE_EN defined: extra register PRESC at BASE_ADDR+12 (PRESC_W bits, reset 0);
//   free-running divider emits a tick every PRESC+1 cycles; TL advances only on ticks; PRESC=0 == no division.
//   Write to PRESC restarts the divider at 0.
// - TIMER_PRESCALE_EN undefined: no PRESC register (address reads 0, writes ignored); TL advances every cycle.
// TESTING
// - Reset: hold reset=0 2 cycles -> rdata of TH/TL/TCON all 0, irq=0, tl_ovf=0.
// - TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011 -> tl_ovf pulse 2 cycles later, TL=FFFF_FFF0, status=1, irq=1 next cycle.
// - irq=1, pulse irq_ack -> irq=0 next cycle; pc_31=1 for 5 cycles then 0 -> FSM IDLE; status still 1 -> irq reasserts.
// - TCON write 3'b011 (clear status) in same cycle as overflow -> status reads 1 afterward.
// - irq_en=0 with overflows -> status stays 0, irq never asserted; pc_31=1 with status set -> irq=0 throughout.
// - TIMER_PRESCALE_EN, PRESC=3, run=1 -> TL increments once every 4 cycles; reset mid-PENDING -> irq=0 next edge.

Source files
------------

// File: rtl/timer_irq_ctrl_if.sv
// Memory-mapped bus between the MEM stage and timer_irq_ctrl.
// rdata is driven combinationally by the slave.
interface timer_irq_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/timer_irq_ctrl.sv
// Interval timer (TH/TL/TCON) with an IRQ handshake FSM for the pipelined MIPS core.
// Optional prescaler register PRESC at BASE_ADDR+12 when TIMER_PRESCALE_EN is defined.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESC_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_ctrl_if.slave  bus,
  input  logic             pc_31,
  input  logic             irq_ack,
  output logic             irq,
  output logic             tl_ovf
);

  typedef enum logic [1:0] {IDLE, PENDING, ENTER, KERNEL} state_e;

  state_e      state_q, state_d;
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic        run_q, run_d, en_q, en_d, status_q, status_d;
  logic        irq_q, irq_d;
  logic        selTh, selTl, selTcon, wrTh, wrTl, wrTcon;
  logic        tick, cntEn, ovf;

  assign selTh   = (bus.addr == BASE_ADDR);
  assign selTl   = (bus.addr == BASE_ADDR + 32'd4);
  assign selTcon = (bus.addr == BASE_ADDR + 32'd8);
  assign wrTh    = bus.we & selTh;
  assign wrTl    = bus.we & selTl;
  assign wrTcon  = bus.we & selTcon;

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d, div_q, div_d;
  logic               selPresc;

  assign selPresc = (bus.addr == BASE_ADDR + 32'd12);
  assign tick     = (div_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    if (bus.we & selPresc) begin
      presc_d = bus.wdata[PRESC_W-1:0];
      div_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      div_q   <= '0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end
`else
  assign tick = (PRESC_W > 0);
`endif

  assign cntEn  = run_q & tick;
  assign ovf    = cntEn & (tl_q == 32'hFFFF_FFFF);
  assign tl_ovf = ovf;

  // Bus writes win over count/reload; an overflow set of status wins over a clear.
  always_comb begin
    th_d     = wrTh ? bus.wdata : th_q;
    tl_d     = tl_q;
    run_d    = run_q;
    en_d     = en_q;
    status_d = status_q;
    if (ovf)        tl_d = th_q;
    else if (cntEn) tl_d = tl_q + 32'd1;
    if (wrTl)       tl_d = bus.wdata;
    if (wrTcon) begin
      run_d = bus.wdata[0];
      en_d  = bus.wdata[1];
      if (!bus.wdata[2]) status_d = 1'b0;
    end
    if (ovf && en_q) status_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (status_q && en_q) state_d = PENDING;
      PENDING: if (irq_ack)          state_d = ENTER;
               else if (!en_q)     state_d = IDLE;
      ENTER:   if (pc_31)            state_d = KERNEL;
      KERNEL:  if (!pc_31)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
    irq_d = (state_d == PENDING);
  end

  // Registered request, masked live while the core is in kernel mode.
  assign irq = irq_q & ~pc_31;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      th_q     <= '0;
      tl_q     <= '0;
      run_q    <= 1'b0;
      en_q     <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      th_q     <= th_d;
      tl_q     <= tl_d;
      run_q    <= run_d;
      en_q     <= en_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.re) begin
      if (selTh)        bus.rdata = th_q;
      else if (selTl)   bus.rdata = tl_q;
      else if (selTcon) bus.rdata = {29'b0, status_q, en_q, run_q};
`ifdef TIMER_PRESCALE_EN
      else if (selPresc) bus.rdata = 32'(presc_q);
`endif
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl (default build, no prescaler):
// directed scenarios followed by randomized bus/pipeline traffic against a behavioural model.
module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE, A_TL = BASE + 32'd4, A_TCON = BASE + 32'd8;

  logic clk = 1'b0;
  logic resetN = 1'b0, pc31 = 1'b0, irqAck = 1'b0;
  wire  irqOut, tlOvfOut;

  timer_irq_ctrl_if busIf ();

  timer_irq_ctrl #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
    .clk(clk), .reset(resetN), .bus(busIf.slave), .pc_31(pc31),
    .irq_ack(irqAck), .irq(irqOut), .tl_ovf(tlOvfOut)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: register contents plus where the handler is in its life cycle.
  logic [31:0] mTh, mTl;
  logic        mRun, mEn, mStatus, mRequest, mValid = 1'b0;
  int          handlerPhase;

  function automatic logic [31:0] modelRead(input logic re, input logic [31:0] a);
    if (!re)      return 32'h0;
    if (a == A_TH) return mTh;
    if (a == A_TL) return mTl;
    if (a == A_TCON) return {29'b0, mStatus, mEn, mRun};
    return 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs currently on the pins.
  task automatic modelStep();
    logic overflow;
    int   nextPhase;
    if (!resetN) begin
      mTh = 0; mTl = 0; mRun = 0; mEn = 0; mStatus = 0;
      handlerPhase = 0; mRequest = 0; mValid = 1'b1;
      return;
    end
    overflow  = mRun && (mTl == 32'hFFFF_FFFF);
    nextPhase = handlerPhase;
    // 0 waiting, 1 requesting, 2 acknowledged, 3 running handler
    if (handlerPhase == 0 && mStatus && mEn) nextPhase = 1;
    else if (handlerPhase == 1 && irqAck)    nextPhase = 2;
    else if (handlerPhase == 1 && !mEn)      nextPhase = 0;
    else if (handlerPhase == 2 && pc31)      nextPhase = 3;
    else if (handlerPhase == 3 && !pc31)     nextPhase = 0;
    if (overflow) mTl = mTh;
    else if (mRun) mTl = mTl + 1;
    if (busIf.we && busIf.addr == A_TL) mTl = busIf.wdata;
    if (busIf.we && busIf.addr == A_TH) mTh = busIf.wdata;
    if (busIf.we && busIf.addr == A_TCON) begin
      if (!busIf.wdata[2]) mStatus = 1'b0;
    end
    if (overflow && mEn) mStatus = 1'b1;
    if (busIf.we && busIf.addr == A_TCON) begin
      mRun = busIf.wdata[0];
      mEn  = busIf.wdata[1];
    end
    handlerPhase = nextPhase;
    mRequest     = (nextPhase == 1);
  endtask

  // One cycle: take the edge, then drive new inputs and check the outputs they produce.
  task automatic applyStimulus(input logic rst, input logic we, input logic re,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic pc, input logic ack, input logic autoAck);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    resetN = rst; busIf.we = we; busIf.re = re; busIf.addr = addr; busIf.wdata = wdata;
    pc31 = pc;
    irqAck = autoAck ? (mRequest && !pc && ($urandom_range(0, 2) == 0)) : ack;
    #1;
    if (mValid) begin
      checkOutput("irq", {31'b0, irqOut}, {31'b0, mRequest && !pc31});
      checkOutput("tl_ovf", {31'b0, tlOvfOut}, {31'b0, mRun && mTl == 32'hFFFF_FFFF});
      checkOutput("rdata", busIf.rdata, modelRead(busIf.re, busIf.addr));
    end
  endtask

  task automatic idle(input logic re, input logic [31:0] a, input logic pc);
    applyStimulus(1'b1, 1'b0, re, a, 32'h0, pc, 1'b0, 1'b0);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic pc);
    applyStimulus(1'b1, 1'b1, 1'b0, a, d, pc, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a, d;
    int sel;
    busIf.we = 0; busIf.re = 0; busIf.addr = 0; busIf.wdata = 0;

    $display("[TB] reset");
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0);
    idle(1'b1, A_TH, 1'b0);   checkOutput("rst_th", busIf.rdata, 32'h0);
    idle(1'b1, A_TL, 1'b0);   checkOutput("rst_tl", busIf.rdata, 32'h0);
    idle(1'b1, A_TCON, 1'b0); checkOutput("rst_tcon", busIf.rdata, 32'h0);
    checkOutput("rst_irq", {31'b0, irqOut}, 32'h0);
    checkOutput("rst_ovf", {31'b0, tlOvfOut}, 32'h0);

    $display("[TB] overflow and reload");
    busWrite(A_TH, 32'hFFFF_FFF0, 1'b0);
    busWrite(A_TL, 32'hFFFF_FFFE, 1'b0);
    busWrite(A_TCON, 32'h3, 1'b0);
    idle(1'b0, 0, 1'b0);  checkOutput("pre_ovf", {31'b0, tlOvfOut}, 32'h0);
    idle(1'b0, 0, 1'b0);  checkOutput("ovf_pulse", {31'b0, tlOvfOut}, 32'h1);
    idle(1'b1, A_TL, 1'b0);
    checkOutput("tl_reload", busIf.rdata, 32'hFFFF_FFF0);
    checkOutput("irq_lag", {31'b0, irqOut}, 32'h0);
    idle(1'b1, A_TCON, 1'b0);
    checkOutput("irq_raised", {31'b0, irqOut}, 32'h1);
    checkOutput("status_set", busIf.rdata, 32'h7);

    $display("[TB] acknowledge and kernel round trip");
    applyStimulus(1'b1, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 0, 1'b0);  checkOutput("irq_after_ack", {31'b0, irqOut}, 32'h0);
    for (int i = 0; i < 5; i++) idle(1'b0, 0, 1'b1);
    idle(1'b0, 0, 1'b0);
    idle(1'b0, 0, 1'b0);  checkOutput("irq_back_idle", {31'b0, irqOut}, 32'h0);
    idle(1'b0, 0, 1'b0);  checkOutput("irq_rearm", {31'b0, irqOut}, 32'h1);

    $display("[TB] clear collides with overflow");
    busWrite(A_TL, 32'hFFFF_FFFE, 1'b0);
    idle(1'b0, 0, 1'b0);
    busWrite(A_TCON, 32'h3, 1'b0);
    checkOutput("ovf_collide", {31'b0, tlOvfOut}, 32'h1);
    idle(1'b1, A_TCON, 1'b0); checkOutput("set_wins", busIf.rdata, 32'h7);
    busWrite(A_TCON, 32'h3, 1'b0);
    idle(1'b1, A_TCON, 1'b0); checkOutput("status_clear", busIf.rdata, 32'h3);

    $display("[TB] interrupts disabled");
    busWrite(A_TCON, 32'h1, 1'b0);
    idle(1'b0, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      idle(1'b1, A_TCON, 1'b0);
      checkOutput("en0_irq", {31'b0, irqOut}, 32'h0);
      checkOutput("en0_status", busIf.rdata, 32'h1);
    end

    $display("[TB] kernel mode masks irq");
    busWrite(A_TCON, 32'h3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      idle(1'b1, A_TCON, 1'b1);
      checkOutput("kmask_irq", {31'b0, irqOut}, 32'h0);
    end
    checkOutput("kmask_status", busIf.rdata, 32'h7);
    idle(1'b0, 0, 1'b0);
    idle(1'b0, 0, 1'b0);  checkOutput("unmask_irq", {31'b0, irqOut}, 32'h1);

    $display("[TB] reset while pending");
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 0, 1'b0);  checkOutput("rst_pending", {31'b0, irqOut}, 32'h0);

    $display("[TB] random traffic");
    busWrite(A_TH, 32'hFFFF_FFE0, 1'b0);
    busWrite(A_TCON, 32'h3, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = A_TH;
        1: a = A_TL;
        2, 3: a = A_TCON;
        4: a = BASE + 32'd12;
        default: a = $urandom;
      endcase
      if (a == A_TCON) d = {$urandom} & 32'h7 | (($urandom_range(0, 3) != 0) ? 32'h3 : 32'h0);
      else d = 32'hFFFF_FF00 | ($urandom & 32'hFF);
      if ($urandom_range(0, 7) == 0) pc31 = ~pc31;
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 1) == 1, a, d, pc31, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
